// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/DMA memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        O_NONE = 2'd0,
        O_CPU  = 2'd1,
        O_DMA  = 2'd2
    } owner_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating DMA wait counter; sat flags that DMA has waited MAX_WAIT cycles.
module mem_arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Held at LIMIT while a CPU lock keeps DMA out, so the forced grant fires on release.
    assign sat = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) single-memory arbiter with CPU priority, DMA starvation
// guard, CPU atomic lock and a one-cycle read response path.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,

    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    input  logic              CPU_LOCK,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,

    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic [ADDR_W-1:0] DMA_ADDR,
    input  logic [DATA_W-1:0] DMA_WDATA,
    output logic              DMA_GNT,
    output logic              DMA_RVALID,
    output logic [DATA_W-1:0] DMA_RDATA,

    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,

    output logic [1:0]        OWNER
);

    logic   cpu_gnt;
    logic   dma_gnt;
    logic   dma_sat;
    owner_e owner_q;

    mem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (DMA_REQ & ~dma_gnt),
        .clr     (~DMA_REQ | dma_gnt),
        .sat     (dma_sat)
    );

    // Grants are gated by RESET_N so nothing is issued while reset is held.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (RESET_N) begin
            if (CPU_REQ && CPU_LOCK) begin
                cpu_gnt = 1'b1;
            end else if (DMA_REQ && dma_sat) begin
                dma_gnt = 1'b1;
            end else if (CPU_REQ) begin
                cpu_gnt = 1'b1;
            end else if (DMA_REQ) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (cpu_gnt) begin
            MEM_EN    = 1'b1;
            MEM_WE    = CPU_WE;
            MEM_ADDR  = CPU_ADDR;
            MEM_WDATA = CPU_WDATA;
        end else if (dma_gnt) begin
            MEM_EN    = 1'b1;
            MEM_WE    = DMA_WE;
            MEM_ADDR  = DMA_ADDR;
            MEM_WDATA = DMA_WDATA;
        end
    end

    // Owner of the read issued last cycle; writes return nothing so they leave O_NONE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q <= O_NONE;
        end else if (cpu_gnt && !CPU_WE) begin
            owner_q <= O_CPU;
        end else if (dma_gnt && !DMA_WE) begin
            owner_q <= O_DMA;
        end else begin
            owner_q <= O_NONE;
        end
    end

    assign CPU_GNT    = cpu_gnt;
    assign DMA_GNT    = dma_gnt;
    assign OWNER      = owner_q;
    assign CPU_RVALID = (owner_q == O_CPU);
    assign DMA_RVALID = (owner_q == O_DMA);
    assign CPU_RDATA  = CPU_RVALID ? MEM_RDATA : '0;
    assign DMA_RDATA  = DMA_RVALID ? MEM_RDATA : '0;

endmodule
